hex_ascii_streamer: RTL
=======================

Name: hex_ascii_streamer

Overview:
Sequencer that takes one binary word per transaction and emits its hexadecimal text form as a serial stream of 8-bit ASCII characters. It sits between register/debug sources and a byte-oriented sink such as the UART TX path. It uses a valid/ready handshake on both sides. It owns a 4-bit-nibble-to-ASCII lookup and schedules that lookup across the nibbles of the word. It can optionally add a "0x" prefix and a CR/LF terminator.

Parameters:
DATA_WIDTH, 32, input word width in bits; must be a multiple of 4, range 4..64
PREFIX_EN, 1, 1 = emit "0x" (0x30, 0x78) before the digits
TERM_EN, 1, 1 = emit CR (0x0D) then LF (0x0A) after the digits

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous reset, active-high
IN_VALID  input  1  IN_DATA holds a word to print
IN_READY  output  1  block can accept a word (high only in IDLE)
IN_DATA  input  DATA_WIDTH  word to print
OUT_VALID  output  1  OUT_CHAR holds a character
OUT_READY  input  1  sink accepts OUT_CHAR this cycle
OUT_CHAR  output  8  ASCII character
BUSY  output  1  high from word accept until the last character handshake

Behaviour:
- Interface: one clock, CLK. Reset is RST, synchronous and active-high. No other clock or reset domain.
- Reset values: OUT_VALID=0, OUT_CHAR=0x00, BUSY=0, state=IDLE, IN_READY=1 in the first cycle after RST deasserts. RST has priority over every other input.
- Nibble map: 0x0-0x9 map to 0x30-0x39; 0xA-0xF map to 0x41-0x46 (uppercase only).
- States: IDLE, PFX0, PFX1, DIGIT, TCR, TLF.
- IDLE:
  - IN_READY=1.
  - On IN_VALID=1, the word is accepted. IN_DATA goes into a shift register, the nibble counter loads DATA_WIDTH/4, and BUSY=1.
  - Next state is PFX0 if PREFIX_EN=1, else DIGIT.
- Output timing: OUT_CHAR and OUT_VALID are registered. The first character is valid in the cycle after the accepting edge (1-cycle latency).
- Handshake:
  - A character transfers when OUT_VALID=1 and OUT_READY=1 on the same edge.
  - While OUT_VALID=1 and OUT_READY=0, OUT_CHAR and the state hold unchanged.
  - OUT_VALID never drops without a transfer, except on RST.
  - At OUT_READY=1 the block presents one character per cycle with no bubbles.
- Character order:
  - PFX0 emits '0' (0x30), then PFX1 emits 'x' (0x78).
  - DIGIT emits nibbles MSB first. Each DIGIT transfer shifts the register left by 4 and decrements the counter.
  - Leading zeros are always printed. Digit count is fixed at DATA_WIDTH/4.
  - After the last digit transfers, go to TCR if TERM_EN=1, else finish.
  - TCR emits 0x0D, then TLF emits 0x0A.
- Finish: on the transfer of the final character, OUT_VALID=0 and BUSY=0 on the next edge, and state returns to IDLE with IN_READY=1.
- Back-to-back words: the minimum gap between the last character of word N and the first character of word N+1 is 2 cycles (one IDLE accept cycle plus the load cycle).
- Characters per word: 2*PREFIX_EN + DATA_WIDTH/4 + 2*TERM_EN.
- IN_READY=0 in every state except IDLE. IN_VALID/IN_DATA outside IDLE are ignored and not captured; the upstream must hold them.
- Reset mid-word: the transaction is aborted at once, no partial flush. Outputs return to reset values on the next edge.
- IN_DATA is sampled only on the accept edge. Later changes do not affect the word in flight.

Test Plan:
- DATA_WIDTH=32, both options on, IN_DATA=0xDEADBEEF, OUT_READY=1 → 12 consecutive cycles of 30 78 44 45 41 44 42 45 45 46 0D 0A. OUT_VALID rises 1 cycle after accept. BUSY falls and IN_READY rises the cycle after 0x0A.
- OUT_READY toggling 1,0,0,1,… on IN_DATA=0x0123ABCD → OUT_CHAR stable during every stall. Sink receives exactly 30 78 30 31 32 33 41 42 43 44 0D 0A, with no duplicates or drops.
- IN_VALID held high with 0x12345678 then 0x9ABCDEF0 queued, OUT_READY=1 → second word accepted only in IDLE. Its first '0' appears exactly 2 cycles after the 0x0A of the first word. Data changes while busy are not captured.
- PREFIX_EN=0, TERM_EN=0, DATA_WIDTH=8, IN_DATA=0x0A → exactly 2 characters, 0x30 then 0x41, then IDLE.
- RST asserted after the 5th character of 0xFFFFFFFF → next edge gives OUT_VALID=0, BUSY=0, IN_READY=1. A new word 0x00000000 then prints the full 12 characters with 8 × 0x30 digits.
- Exhaustive nibble sweep with DATA_WIDTH=4, options off, IN_DATA=0x0..0xF → single characters 0x30..0x39, 0x41..0x46.

Source files
------------

// File: rtl/hex_ascii_streamer.sv
// Streams one DATA_WIDTH-bit word as uppercase hex ASCII characters, MSB nibble first,
// with optional "0x" prefix and CR/LF terminator, over valid/ready handshakes.
module hex_ascii_streamer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          PREFIX_EN  = 1'b1,
    parameter bit          TERM_EN    = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [DATA_WIDTH-1:0] IN_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [7:0]            OUT_CHAR,
    output logic                  BUSY
);

    localparam int unsigned NDIG = DATA_WIDTH / 4;
    localparam int unsigned CW   = $clog2(NDIG + 1);

    typedef enum logic [2:0] {
        IDLE,
        PFX0,
        PFX1,
        DIGIT,
        TCR,
        TLF
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CW-1:0]         r_cnt;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [7:0]            r_out_char;
    logic                  r_busy;

    logic                  w_xfer;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic [7:0]            w_first_digit;
    logic [7:0]            w_head_digit;
    logic [7:0]            w_next_digit;

    function automatic logic [7:0] nib2ascii(input logic [3:0] n);
        nib2ascii = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign w_xfer        = r_out_valid & OUT_READY;
    assign w_shift_next  = r_shift << 4;
    assign w_first_digit = nib2ascii(IN_DATA[DATA_WIDTH-1 -: 4]);
    assign w_head_digit  = nib2ascii(r_shift[DATA_WIDTH-1 -: 4]);
    assign w_next_digit  = nib2ascii(w_shift_next[DATA_WIDTH-1 -: 4]);

    // OUT_CHAR always holds the character of the current state; each transfer
    // pre-loads the next character so the sink sees one character per cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_char  <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (IN_VALID) begin
                        r_shift     <= IN_DATA;
                        r_cnt       <= CW'(NDIG);
                        r_busy      <= 1'b1;
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                        if (PREFIX_EN) begin
                            r_state    <= PFX0;
                            r_out_char <= 8'h30;
                        end else begin
                            r_state    <= DIGIT;
                            r_out_char <= w_first_digit;
                        end
                    end
                end
                PFX0: begin
                    if (w_xfer) begin
                        r_state    <= PFX1;
                        r_out_char <= 8'h78;
                    end
                end
                PFX1: begin
                    if (w_xfer) begin
                        r_state    <= DIGIT;
                        r_out_char <= w_head_digit;
                    end
                end
                DIGIT: begin
                    if (w_xfer) begin
                        r_shift <= w_shift_next;
                        r_cnt   <= r_cnt - CW'(1);
                        if (r_cnt == CW'(1)) begin
                            if (TERM_EN) begin
                                r_state    <= TCR;
                                r_out_char <= 8'h0D;
                            end else begin
                                r_state     <= IDLE;
                                r_out_valid <= 1'b0;
                                r_busy      <= 1'b0;
                                r_in_ready  <= 1'b1;
                            end
                        end else begin
                            r_out_char <= w_next_digit;
                        end
                    end
                end
                TCR: begin
                    if (w_xfer) begin
                        r_state    <= TLF;
                        r_out_char <= 8'h0A;
                    end
                end
                TLF: begin
                    if (w_xfer) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign IN_READY  = r_in_ready;
    assign OUT_VALID = r_out_valid;
    assign OUT_CHAR  = r_out_char;
    assign BUSY      = r_busy;

endmodule
